// File: rtl/iiitb_wm_input_cond.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : iiitb_wm_input_cond
// Purpose  : Input conditioning for the washing-machine FSM: sync/debounce of
//            door and start, start pulse, cycle/spin timers, door fault flag.
// Revision : 1.0 - initial release
// ============================================================================
module iiitb_wm_input_cond #(
   parameter int DEB_CYCLES  = 4,
   parameter int PRESCALE    = 1,
   parameter int CNT_W       = 16,
   parameter int CYCLE_TICKS = 10,
   parameter int SPIN_TICKS  = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic door_close_raw,
   input  logic start_raw,
   input  logic motor_on,
   input  logic drain_value_on,
   input  logic door_lock,
   output logic door_close,
   output logic start,
   output logic cycle_timeout,
   output logic spin_timeout,
   output logic door_fault
);

   localparam int                c_DEB_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0]  c_PRE_LAST = CNT_W'(PRESCALE - 1);

   // Bit 0 = door channel, bit 1 = start channel.
   logic [1:0] w_raw;
   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] w_deb;
   logic [1:0] w_flip;
   // Bit 0 = cycle timer (motor_on), bit 1 = spin timer (drain_value_on).
   logic [1:0] w_en;
   logic [1:0] w_to;
   logic       r_start;
   logic       r_fault;

   assign w_raw = {start_raw, door_close_raw};
   assign w_en  = {drain_value_on, motor_on};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_deb
      logic               r_level;
      logic [c_DEB_W-1:0] r_cnt;

      assign w_deb[g]  = r_level;
      assign w_flip[g] = (r_sync2[g] != r_level) && (r_cnt == c_DEB_LAST);

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
         end else if (r_sync2[g] != r_level) begin
            if (r_cnt == c_DEB_LAST) begin
               r_level <= ~r_level;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_tmr
      localparam int               c_N        = (g == 0) ? CYCLE_TICKS : SPIN_TICKS;
      localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(c_N - 1);

      logic [CNT_W-1:0] r_pre;
      logic [CNT_W-1:0] r_cnt;
      logic             r_to;

      assign w_to[g] = r_to;

      // Once expired, everything freezes until the enable drops.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_pre <= '0;
            r_cnt <= '0;
            r_to  <= 1'b0;
         end else if (!w_en[g]) begin
            r_pre <= '0;
            r_cnt <= '0;
            r_to  <= 1'b0;
         end else if (!r_to) begin
            if (r_pre == c_PRE_LAST) begin
               r_pre <= '0;
               if (r_cnt == c_CNT_LAST) begin
                  r_to <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end else begin
               r_pre <= r_pre + 1'b1;
            end
         end
      end
   end

   // Start pulse coincides with the debounced rise; a locked door drops it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_start <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_start <= w_flip[1] & ~w_deb[1] & ~door_lock;
         r_fault <= r_fault | (w_flip[0] & w_deb[0] & door_lock);
      end
   end

   assign door_close    = w_deb[0];
   assign start         = r_start;
   assign cycle_timeout = w_to[0];
   assign spin_timeout  = w_to[1];
   assign door_fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_iiitb_wm_input_cond.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_iiitb_wm_input_cond
// Purpose  : Scoreboard bench for the washing-machine input conditioner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iiitb_wm_input_cond;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic door_close_raw = 1'b0, start_raw = 1'b0;
   logic motor_on = 1'b0, drain_value_on = 1'b0, door_lock = 1'b0;
   logic door_close, start, cycle_timeout, spin_timeout, door_fault;

   logic motor_b = 1'b0, drain_b = 1'b0, tie_lo = 1'b0;
   logic door_close_b, start_b, cycle_timeout_b, spin_timeout_b, door_fault_b;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int    at;
      int    sel;
      bit    val;
      string tag;
   } exp_t;
   exp_t sb[$];

   iiitb_wm_input_cond u_dut (
      .clk(clk), .reset(reset),
      .door_close_raw(door_close_raw), .start_raw(start_raw),
      .motor_on(motor_on), .drain_value_on(drain_value_on), .door_lock(door_lock),
      .door_close(door_close), .start(start), .cycle_timeout(cycle_timeout),
      .spin_timeout(spin_timeout), .door_fault(door_fault)
   );

   iiitb_wm_input_cond #(.PRESCALE(3)) u_dut_b (
      .clk(clk), .reset(reset),
      .door_close_raw(tie_lo), .start_raw(tie_lo),
      .motor_on(motor_b), .drain_value_on(drain_b), .door_lock(tie_lo),
      .door_close(door_close_b), .start(start_b), .cycle_timeout(cycle_timeout_b),
      .spin_timeout(spin_timeout_b), .door_fault(door_fault_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input bit got, input bit exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0b expected %0b", tag, cyc, got, exp);
      end
   endtask

   function automatic bit obs(input int sel);
      case (sel)
         0:       return door_close;
         1:       return start;
         2:       return cycle_timeout;
         3:       return spin_timeout;
         4:       return door_fault;
         5:       return cycle_timeout_b;
         default: return spin_timeout_b;
      endcase
   endfunction

   // Queue an expectation for the output selected by sel, off edges from now.
   task automatic expect_at(input int off, input int sel, input bit val, input string tag);
      exp_t e;
      e.at  = cyc + off;
      e.sel = sel;
      e.val = val;
      e.tag = tag;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            chk(sb[i].tag, obs(sb[i].sel), sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1;
      for (int s = 0; s < 5; s++) chk("reset_state", obs(s), 1'b0);
      idle(3);
      reset = 1'b1;
      idle(2);

      // Door: 3-clk glitch must be filtered, clean edge lands 6 clk later.
      door_close_raw = 1'b1;
      for (int k = 1; k <= 10; k++) expect_at(k, 0, 1'b0, "door_glitch");
      idle(3);
      door_close_raw = 1'b0;
      idle(10);
      door_close_raw = 1'b1;
      expect_at(5, 0, 1'b0, "door_pre");
      expect_at(6, 0, 1'b1, "door_rise");
      expect_at(12, 0, 1'b1, "door_hold");
      idle(14);

      // Start pulse, unlocked then locked.
      start_raw = 1'b1;
      expect_at(5, 1, 1'b0, "start_pre");
      expect_at(6, 1, 1'b1, "start_pulse");
      expect_at(7, 1, 1'b0, "start_post");
      expect_at(15, 1, 1'b0, "start_held");
      idle(20);
      start_raw = 1'b0;
      idle(10);
      door_lock = 1'b1;
      idle(1);
      start_raw = 1'b1;
      for (int k = 1; k <= 12; k++) expect_at(k, 1, 1'b0, "start_locked");
      expect_at(12, 4, 1'b0, "no_fault");
      idle(14);
      start_raw = 1'b0;
      idle(10);
      door_lock = 1'b0;
      idle(1);

      // Cycle timer: arm, abort for one clk, re-arm.
      motor_on = 1'b1;
      expect_at(9, 2, 1'b0, "cyc_pre");
      expect_at(10, 2, 1'b1, "cyc_rise");
      expect_at(16, 2, 1'b1, "cyc_sticky");
      idle(20);
      motor_on = 1'b0;
      idle(1);
      motor_on = 1'b1;
      expect_at(0, 2, 1'b0, "cyc_abort");
      expect_at(9, 2, 1'b0, "cyc_rearm_pre");
      expect_at(10, 2, 1'b1, "cyc_rearm_rise");
      idle(12);
      motor_on = 1'b0;
      idle(2);

      // Partial run then restart: full period again.
      motor_on = 1'b1;
      idle(7);
      motor_on = 1'b0;
      idle(1);
      motor_on = 1'b1;
      expect_at(3, 2, 1'b0, "cyc_no_resume");
      expect_at(9, 2, 1'b0, "cyc_restart_pre");
      expect_at(10, 2, 1'b1, "cyc_restart_rise");
      idle(12);
      motor_on = 1'b0;
      idle(2);

      // Spin timer alone.
      drain_value_on = 1'b1;
      expect_at(5, 3, 1'b0, "spin_pre");
      expect_at(6, 3, 1'b1, "spin_rise");
      expect_at(10, 3, 1'b1, "spin_sticky");
      expect_at(10, 2, 1'b0, "spin_indep");
      idle(12);
      drain_value_on = 1'b0;
      idle(2);

      // Prescaled instance, both timers together.
      drain_b = 1'b1;
      motor_b = 1'b1;
      expect_at(17, 6, 1'b0, "ps_spin_pre");
      expect_at(18, 6, 1'b1, "ps_spin_rise");
      expect_at(29, 5, 1'b0, "ps_cyc_pre");
      expect_at(30, 5, 1'b1, "ps_cyc_rise");
      idle(32);
      drain_b = 1'b0;
      motor_b = 1'b0;
      idle(2);

      // Door opened while locked.
      door_lock = 1'b1;
      door_close_raw = 1'b0;
      expect_at(5, 4, 1'b0, "fault_pre");
      expect_at(6, 0, 1'b0, "door_fall");
      expect_at(6, 4, 1'b1, "fault_set");
      expect_at(12, 4, 1'b1, "fault_sticky");
      idle(14);
      door_lock = 1'b0;
      door_close_raw = 1'b1;
      motor_on = 1'b1;
      expect_at(6, 0, 1'b1, "door_reclose");
      expect_at(10, 2, 1'b1, "cyc_before_rst");
      expect_at(12, 4, 1'b1, "fault_before_rst");
      idle(14);

      // Asynchronous reset mid-cycle.
      #2;
      reset = 1'b0;
      #1;
      for (int s = 0; s < 5; s++) chk("async_reset", obs(s), 1'b0);
      idle(2);
      reset = 1'b1;
      expect_at(5, 0, 1'b0, "rst_door_pre");
      expect_at(6, 0, 1'b1, "rst_door_rise");
      expect_at(9, 2, 1'b0, "rst_cyc_pre");
      expect_at(10, 2, 1'b1, "rst_cyc_rise");
      expect_at(10, 4, 1'b0, "rst_fault_clr");
      idle(12);
      motor_on = 1'b0;
      idle(2);

      foreach (sb[i]) begin
         total++;
         bad++;
         $display("FAIL %s: expectation for cyc %0d never checked", sb[i].tag, sb[i].at);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
